// File: rtl/alu_arbiter.sv
// Two-requester arbiter and single-stage issue sequencer in front of one shared ALU,
// with one response buffer per requester. Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic              alu_src2_sel_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Requesters may drop valid at any time; ready never depends on anything registered later.
  logic              s1_valid_q, s1_valid_d;
  logic              s1_tag_q, s1_tag_d;
  logic [OP_W-1:0]   s1_op_q, s1_op_d;
  logic [DATA_W-1:0] s1_src1_q, s1_src1_d;
  logic [DATA_W-1:0] s1_src2_q, s1_src2_d;

  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_zero_q, rsp_zero_d;
  logic [DATA_W-1:0] rsp_result_q [2];
  logic [DATA_W-1:0] rsp_result_d [2];

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic              last_grant_q, last_grant_d;
`endif

  logic [1:0] busy;
  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] rsp_ready;

  assign rsp_ready = {rsp1_ready, rsp0_ready};

  always_comb begin
    busy[0] = (s1_valid_q && !s1_tag_q) || rsp_valid_q[0];
    busy[1] = (s1_valid_q &&  s1_tag_q) || rsp_valid_q[1];
    elig    = {req1_valid && !busy[1], req0_valid && !busy[0]};
    grant   = 2'b00;
    if (!rst) begin
      if (elig == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = 2'b01;
`else
        grant = last_grant_q ? 2'b01 : 2'b10;
`endif
      end else begin
        grant = elig;
      end
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Issue stage: operand registers hold when idle; the ALU drive is zeroed separately.
  always_comb begin
    s1_valid_d = |grant;
    s1_tag_d   = s1_tag_q;
    s1_op_d    = s1_op_q;
    s1_src1_d  = s1_src1_q;
    s1_src2_d  = s1_src2_q;
    if (grant[1]) begin
      s1_tag_d  = 1'b1;
      s1_op_d   = req1_op;
      s1_src1_d = req1_src1;
      s1_src2_d = req1_src2;
    end else if (grant[0]) begin
      s1_tag_d  = 1'b0;
      s1_op_d   = req0_op;
      s1_src1_d = req0_src1;
      s1_src2_d = req0_src2;
    end
  end

  // Capture and drain of one requester never coincide because busy blocks re-issue.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_result_d = rsp_result_q;
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
      if (s1_valid_q && (s1_tag_q == 1'(i))) begin
        rsp_valid_d[i]  = 1'b1;
        rsp_result_d[i] = alu_result_i;
        rsp_zero_d[i]   = alu_zero_i;
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (|grant) begin
      last_grant_d = grant[1];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q      <= 1'b0;
      s1_tag_q        <= 1'b0;
      s1_op_q         <= '0;
      s1_src1_q       <= '0;
      s1_src2_q       <= '0;
      rsp_valid_q     <= 2'b00;
      rsp_zero_q      <= 2'b00;
      rsp_result_q[0] <= '0;
      rsp_result_q[1] <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q    <= 1'b1;
`endif
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_tag_q        <= s1_tag_d;
      s1_op_q         <= s1_op_d;
      s1_src1_q       <= s1_src1_d;
      s1_src2_q       <= s1_src2_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_zero_q      <= rsp_zero_d;
      rsp_result_q[0] <= rsp_result_d[0];
      rsp_result_q[1] <= rsp_result_d[1];
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q    <= last_grant_d;
`endif
    end
  end

  assign alu_op_o       = s1_valid_q ? s1_op_q   : '0;
  assign alu_src1_o     = s1_valid_q ? s1_src1_q : '0;
  assign alu_src2_o     = s1_valid_q ? s1_src2_q : '0;
  assign alu_src2_sel_o = 1'b0;

  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = rsp_result_q[0];
  assign rsp1_result = rsp_result_q[1];
  assign rsp0_zero   = rsp_zero_q[0];
  assign rsp1_zero   = rsp_zero_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, transaction-level arbitration/latency model,
// and a response scoreboard with one expected queue per requester.
module tb_alu_arbiter;
  localparam int DATA_W = 32;
  localparam int OP_W   = 5;
  localparam logic [OP_W-1:0] ALU_ADD = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 5'd1;
  localparam logic [OP_W-1:0] ALU_AND = 5'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 5'd3;
  localparam logic [OP_W-1:0] ALU_XOR = 5'd4;
  localparam logic [OP_W-1:0] ALU_SLL = 5'd5;
  localparam logic [OP_W-1:0] ALU_SRL = 5'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [OP_W-1:0]   req0_op = '0, req1_op = '0;
  logic [DATA_W-1:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
  logic rsp0_valid, rsp1_valid;
  logic rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [DATA_W-1:0] rsp0_result, rsp1_result;
  logic rsp0_zero, rsp1_zero;
  logic [OP_W-1:0]   alu_op_o;
  logic [DATA_W-1:0] alu_src1_o, alu_src2_o;
  logic alu_src2_sel_o;
  logic [DATA_W-1:0] alu_result_i;
  logic alu_zero_i;

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_op_o(alu_op_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_src2_sel_o(alu_src2_sel_o), .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  assign alu_result_i = alu_fn(alu_op_o, alu_src1_o, alu_src2_o);
  assign alu_zero_i   = (alu_result_i == '0);

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W:0] exp_q0[$];
  logic [DATA_W:0] exp_q1[$];
  bit mon_en = 1'b0;

  // reference model state
  bit pend[2];
  int acc_cyc[2];
  bit last_g;
  int cyc;
  bit prev_v;
  logic [OP_W-1:0]   prev_op;
  logic [DATA_W-1:0] prev_a, prev_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    pend    = '{0, 0};
    acc_cyc = '{0, 0};
    last_g  = 1'b1;
    prev_v  = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // driver tasks
  task automatic set_idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [OP_W-1:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (i == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_src1 = a; req0_src2 = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_src1 = a; req1_src2 = b;
    end
  endtask

  // Called at a falling edge with inputs already driven; checks the cycle, advances the model.
  task automatic step();
    bit v[2], rr[2], erv[2], elig[2];
    logic [OP_W-1:0]   op[2];
    logic [DATA_W-1:0] a[2], b[2], res;
    int gi;
    #1;
    v  = '{req0_valid, req1_valid};
    rr = '{rsp0_ready, rsp1_ready};
    op = '{req0_op, req1_op};
    a  = '{req0_src1, req1_src1};
    b  = '{req0_src2, req1_src2};
    check("alu_op",   64'(alu_op_o),   prev_v ? 64'(prev_op) : 64'd0);
    check("alu_src1", 64'(alu_src1_o), prev_v ? 64'(prev_a)  : 64'd0);
    check("alu_src2", 64'(alu_src2_o), prev_v ? 64'(prev_b)  : 64'd0);
    check("alu_src2_sel", 64'(alu_src2_sel_o), 64'd0);
    for (int i = 0; i < 2; i++) erv[i] = pend[i] && (cyc >= acc_cyc[i] + 2);
    check("rsp0_valid", 64'(rsp0_valid), 64'(erv[0]));
    check("rsp1_valid", 64'(rsp1_valid), 64'(erv[1]));
    gi = -1;
    if (!rst) begin
      for (int i = 0; i < 2; i++) elig[i] = v[i] && !pend[i];
      if (elig[0] && elig[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        gi = 0;
`else
        gi = last_g ? 0 : 1;
`endif
      end else if (elig[0]) gi = 0;
      else if (elig[1]) gi = 1;
    end
    check("req0_ready", 64'(req0_ready), 64'(gi == 0));
    check("req1_ready", 64'(req1_ready), 64'(gi == 1));
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) if (erv[i] && rr[i]) pend[i] = 1'b0;
      prev_v = (gi >= 0);
      if (gi >= 0) begin
        pend[gi]    = 1'b1;
        acc_cyc[gi] = cyc;
        last_g      = (gi == 1);
        prev_op     = op[gi];
        prev_a      = a[gi];
        prev_b      = b[gi];
        res         = alu_fn(op[gi], a[gi], b[gi]);
        if (gi == 0) exp_q0.push_back({res == '0, res});
        else         exp_q1.push_back({res == '0, res});
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // monitor: compares whatever response is presented, pops on handshake
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && !rst) begin
        if (rsp0_valid === 1'b1) begin
          if (exp_q0.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rsp0_unexpected @cyc %0d: got result %0h expected none", cyc, rsp0_result);
          end else begin
            check("rsp0_result", 64'(rsp0_result), 64'(exp_q0[0][DATA_W-1:0]));
            check("rsp0_zero",   64'(rsp0_zero),   64'(exp_q0[0][DATA_W]));
            if (rsp0_ready) void'(exp_q0.pop_front());
          end
        end
        if (rsp1_valid === 1'b1) begin
          if (exp_q1.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rsp1_unexpected @cyc %0d: got result %0h expected none", cyc, rsp1_result);
          end else begin
            check("rsp1_result", 64'(rsp1_result), 64'(exp_q1[0][DATA_W-1:0]));
            check("rsp1_zero",   64'(rsp1_zero),   64'(exp_q1[0][DATA_W]));
            if (rsp1_ready) void'(exp_q1.pop_front());
          end
        end
      end
    end
  end

  initial begin
    cyc = 0;
    model_reset();
    // reset with both requesters asking: nothing may be granted
    rst = 1'b1;
    set_idle();
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    set_req(1, ALU_ADD, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    #1;
    check("rst_req0_ready", 64'(req0_ready), 64'd0);
    check("rst_req1_ready", 64'(req1_ready), 64'd0);
    check("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    check("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    check("rst_alu_op",     64'(alu_op_o),   64'd0);
    check("rst_alu_src1",   64'(alu_src1_o), 64'd0);
    check("rst_rsp0_result", 64'(rsp0_result), 64'd0);
    check("rst_rsp1_result", 64'(rsp1_result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    mon_en = 1'b1;

    // single op: ADD 5+7 from requester 0
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    step();
    set_idle();
    check("single_alu_src1", 64'(alu_src1_o), 64'd5);
    step();
    check("single_rsp0_valid",  64'(rsp0_valid),  64'd1);
    check("single_rsp0_result", 64'(rsp0_result), 64'd12);
    check("single_rsp0_zero",   64'(rsp0_zero),   64'd0);
    step();
    repeat (2) step();

    // tie: both valid every cycle
    set_req(0, ALU_SUB, 32'd9, 32'd9);
    set_req(1, ALU_XOR, 32'hF0, 32'h0F);
    repeat (12) step();
    set_idle();
    repeat (4) step();
    check("tie_rsp0_result", 64'(rsp0_result), 64'd0);
    check("tie_rsp0_zero",   64'(rsp0_zero),   64'd1);
    check("tie_rsp1_result", 64'(rsp1_result), 64'hFF);

    // backpressure on requester 0 while requester 1 keeps flowing
    rsp0_ready = 1'b0;
    set_req(0, ALU_OR, 32'h1234_0000, 32'h0000_5678);
    set_req(1, ALU_ADD, 32'd100, 32'd23);
    repeat (10) step();
    check("bp_rsp0_hold", 64'(rsp0_result), 64'h1234_5678);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    set_req(0, ALU_SLL, 32'd1, 32'd4);
    repeat (6) step();
    rsp0_ready = 1'b1;
    set_idle();
    repeat (4) step();

    // reset the cycle after a requester-1 accept
    set_req(1, ALU_ADD, 32'hAAAA, 32'h5555);
    step();
    set_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_rsp1_result", 64'(rsp1_result), 64'd0);
    check("post_rst_rsp0_result", 64'(rsp0_result), 64'd0);
    check("post_rst_alu_src2",    64'(alu_src2_o),  64'd0);
    set_req(0, ALU_AND, 32'hFF00, 32'h0FF0);
    set_req(1, ALU_SRL, 32'h8000, 32'd3);
    step();
    set_idle();
    repeat (4) step();

    // idle
    repeat (10) step();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      req0_op    = OP_W'($urandom_range(0, 6));
      req1_op    = OP_W'($urandom_range(0, 6));
      req0_src1  = $urandom;
      req1_src1  = $urandom;
      req0_src2  = ($urandom_range(0, 3) == 0) ? req0_src1 : $urandom;
      req1_src2  = ($urandom_range(0, 3) == 0) ? req1_src1 : $urandom;
      step();
    end

    // drain
    rst = 1'b0;
    set_idle();
    for (int n = 0; n < 20; n++) begin
      if (!pend[0] && !pend[1]) break;
      step();
    end
    step();
    check("drain_q0_empty", 64'(exp_q0.size()), 64'd0);
    check("drain_q1_empty", 64'(exp_q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and issue sequencer for the shared integer ALU. It accepts operations from two independent requesters over valid/ready handshakes and arbitrates between them, round-robin by default. Each accepted operation is registered into a single issue stage that drives the ALU operand ports. The ALU result is captured into a per-requester response buffer. It sits between the execute-stage issue logic (requester 0) and an auxiliary unit such as the address/CSR helper (requester 1), in front of one ALU instance.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 5, ALU opcode width (matches `ALU_*` encodings in defines.svh)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has an operation
- req0_ready / req1_ready  out  1  operation accepted this cycle when valid&ready
- req0_op / req1_op  in  OP_W  ALU opcode
- req0_src1 / req1_src1  in  DATA_W  operand 1
- req0_src2 / req1_src2  in  DATA_W  operand 2 (immediates pre-selected by requester)
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  requester consumes result
- rsp0_result / rsp1_result  out  DATA_W  captured alu_result
- rsp0_zero / rsp1_zero  out  1  captured zero flag
- alu_op_o  out  OP_W  to ALU alu_op
- alu_src1_o, alu_src2_o  out  DATA_W  to ALU src1/src2
- alu_src2_sel_o  out  1  constant 0 (src2 always used)
- alu_result_i  in  DATA_W  from ALU
- alu_zero_i  in  1  from ALU zero

## Operation
- Busy: busy_i = (s1_valid && s1_tag==i) || rsp_i_valid. There is at most one outstanding op per requester.
- Eligible: elig_i = req_i_valid && !busy_i.
- Grant (round-robin):
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester not equal to last_grant is granted.
  - last_grant updates only on an accepted grant.
  - Reset value of last_grant = 1, so requester 0 wins the first tie.
- req_i_ready = granted_i. It is combinational from valid/busy/last_grant. At most one ready is high per cycle.
- Issue stage, on accept: s1_valid<=1, s1_tag<=i, s1_op/src1/src2<=request fields. With no accept: s1_valid<=0.
- ALU drive:
  - When s1_valid=1, alu_op_o/alu_src1_o/alu_src2_o come from the s1 registers.
  - When s1_valid=0, they are driven to 0 (op 0 = `ALU_ADD`, 0+0; keeps ALU inputs quiet).
- Capture: when s1_valid, at the clock edge rsp[s1_tag]_result<=alu_result_i, rsp[s1_tag]_zero<=alu_zero_i, rsp[s1_tag]_valid<=1.
- Drain: rsp_i_valid clears on the edge where rsp_i_valid && rsp_i_ready. The result/zero registers hold their last value while invalid.
- Capture and drain of the same requester never coincide: busy forbids a new issue while rsp_i_valid=1.
- Arithmetic is entirely inside the ALU. This block performs no width conversion; it passes DATA_W values through unchanged.

## Timing
- Request accepted at edge N → ALU driven during cycle N+1 → rsp_valid high from cycle N+2 (2-cycle latency).
- Per-requester throughput: 1 op per 3 cycles when rsp_ready is held high.
  - Accept at N, response at N+2, drained at the end of N+2, next accept at N+3.
  - The two requesters interleave, keeping the ALU busy up to 2 of every 3 cycles.
- req_i_valid may drop without acceptance; there is no stickiness requirement on requesters.
- Reset (mid-operation included): s1_valid=0, rsp0_valid=rsp1_valid=0, rsp results/zero=0, last_grant=1.
  - All ALU drive outputs read 0.
  - Any in-flight op is discarded and is not delivered after reset.
- Output values during and after reset:
  - req_i_ready reads 0 during the rst cycle.
  - After reset deassertion, req_i_ready follows the grant rule.
  - alu_src2_sel_o=0 always.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - When defined, requester 0 always wins a tie (fixed priority). last_grant is not implemented.
  - When undefined (default), round-robin as above.

## Test plan
- Single op: req0 `ALU_ADD` src1=5, src2=7 accepted at edge N → alu_op_o=`ALU_ADD`, alu_src1_o=5 in N+1; rsp0_valid=1, rsp0_result=12, rsp0_zero=0 at N+2.
- Tie, round-robin:
  - Stimulus: both requesters valid every cycle, rsp_ready=1; req0 `ALU_SUB` 9-9, req1 `ALU_XOR` 0xF0^0x0F.
  - First grant goes to req0, next to req1, alternating.
  - rsp0_result=0 with rsp0_zero=1; rsp1_result=0xFF.
- Backpressure:
  - Stimulus: rsp0_ready=0 after a req0 op completes, req0_valid held high.
  - req0_ready stays 0 and rsp0_result stays stable.
  - req1 continues to be served.
  - Raising rsp0_ready for 1 cycle allows a new req0 accept on the following cycle.
- Reset mid-flight: assert rst the cycle after a req1 accept → rsp1_valid never rises; all outputs 0; the first tie after reset is granted to req0.
- Idle: no valid for 10 cycles → alu_op_o, alu_src1_o and alu_src2_o remain 0, and both rsp_valid remain 0.
- ALU_ARB_FIXED_PRIO_EN defined, both requesters continuously valid with rsp_ready=1:
  - req0 is granted at every opportunity (accepts at N, N+3, N+6, …).
  - req1 is granted only in cycles where req0 is busy.
